data_mem_ctrl: RTL and testbench

Parametrised, multi-cycle data memory for the MIPS core's MEM stage. It replaces the single-cycle word-only memory with a request/response interface, configurable wait states and byte/halfword/word access. Loads are sign- or zero-extended, and misaligned or out-of-range accesses are reported as faults. The pipeline stalls on `req_ready`/`resp_valid` instead of assuming a zero-latency read.

---
 rtl/data_mem_pkg.sv | 65 ++++++
 rtl/data_mem_array.sv | 23 ++
 rtl/data_mem_ctrl.sv | 132 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data memory.
package data_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Byte enables plus store data replicated into every candidate lane.
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } merge_t;

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                              input logic [1:0]  addr_lo,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = 8'(word >> {addr_lo, 3'b000});
    h = 16'(word >> {addr_lo[1], 4'b0000});
    case (size)
      SIZE_B:  r = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_H:  r = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Store alignment: lanes are selected by byte enables, data is replicated
  // so that whichever lanes are enabled already hold the right bytes.
  function automatic merge_t lane_merge(input logic [31:0] wdata,
                                        input logic [1:0]  addr_lo,
                                        input logic [1:0]  size);
    merge_t m;
    case (size)
      SIZE_B: begin
        m.be   = 4'b0001 << addr_lo;
        m.data = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        m.be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        m.data = {2{wdata[15:0]}};
      end
      SIZE_W: begin
        m.be   = 4'b1111;
        m.data = wdata;
      end
      default: begin
        m.be   = 4'b0000;
        m.data = wdata;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-wide RAM with per-byte write enables and a registered read port.
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write and read-before-write registered read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Request/response data memory with wait states, sub-word access and faults.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state;
  logic [3:0]    wcnt;

  logic          cap_write, cap_unsigned, cap_fault;
  logic [1:0]    cap_size;
  logic [AW+1:0] cap_addr;
  logic [31:0]   cap_wdata;

  logic          accept, req_fault, commit;
  logic [31:0]   widx;
  logic          sel_write;
  logic [1:0]    sel_size;
  logic [AW+1:0] sel_addr;
  logic [31:0]   sel_wdata;
  merge_t        mrg;
  logic [3:0]    mem_be;
  logic [31:0]   rd_word;

  assign accept = (state == ST_IDLE) && req_valid;

  // Reject illegal size, misalignment and out-of-range word index.
  always_comb begin
    widx      = {2'b00, req_addr[31:2]};
    req_fault = 1'b0;
    if (req_size == 2'b11)                            req_fault = 1'b1;
    if ((req_size == SIZE_H) && req_addr[0])          req_fault = 1'b1;
    if ((req_size == SIZE_W) && (req_addr[1:0] != 0)) req_fault = 1'b1;
    if (widx >= 32'(DEPTH_WORDS))                     req_fault = 1'b1;
  end

  // With no wait states the access happens on the acceptance edge, so the
  // live request drives the array; otherwise the captured copy does.
  always_comb begin
    if (state == ST_IDLE) begin
      sel_write = req_write;
      sel_size  = req_size;
      sel_addr  = req_addr[AW+1:0];
      sel_wdata = req_wdata;
    end else begin
      sel_write = cap_write;
      sel_size  = cap_size;
      sel_addr  = cap_addr;
      sel_wdata = cap_wdata;
    end
  end

  assign commit = (WAIT_CYCLES == 0) ? (accept && !req_fault)
                                     : ((state == ST_WAIT) && (wcnt == 4'd0));
  assign mrg    = lane_merge(sel_wdata, sel_addr[1:0], sel_size);
  assign mem_be = (commit && sel_write) ? mrg.be : 4'b0000;

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .addr  (sel_addr[AW+1:2]),
    .be    (mem_be),
    .wdata (mrg.data),
    .rdata (rd_word)
  );

  // Control FSM: IDLE accepts, WAIT counts down, RESP pulses for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      wcnt  <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_fault || (WAIT_CYCLES == 0)) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              wcnt  <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (wcnt == 4'd0) state <= ST_RESP;
          else              wcnt  <= wcnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request capture; data path only, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write    <= req_write;
      cap_size     <= req_size;
      cap_unsigned <= req_unsigned;
      cap_addr     <= req_addr[AW+1:0];
      cap_wdata    <= req_wdata;
      cap_fault    <= req_fault;
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_fault = resp_valid && cap_fault;
  assign resp_rdata = (resp_valid && !cap_fault && !cap_write)
                      ? lane_extend(rd_word, cap_addr[1:0], cap_size, cap_unsigned)
                      : 32'h0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one WAIT_CYCLES=2 instance and one WAIT_CYCLES=0 instance.
module tb_data_mem_ctrl;
  import data_mem_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        va, vb;
  logic        req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        ra, rb, rva, rvb, fa, fb;
  logic [31:0] da, db;

  bit          sel;
  logic        rdy_s, rv_s, flt_s;
  logic [31:0] rd_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(ra),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rva), .resp_rdata(da), .resp_fault(fa)
  );

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(rb),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvb), .resp_rdata(db), .resp_fault(fb)
  );

  assign rdy_s = sel ? rb  : ra;
  assign rv_s  = sel ? rvb : rva;
  assign flt_s = sel ? fb  : fa;
  assign rd_s  = sel ? db  : da;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  // One full transaction; hs_ok covers ready low while busy and a one-cycle pulse.
  task automatic tx(input string tag, input bit s, input logic wr, input logic [1:0] sz,
                    input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_flt, input int exp_lat);
    int          guard;
    int          lat;
    bit          hs_ok;
    logic [31:0] rd;
    logic        flt;
    sel = s;
    guard = 0;
    @(negedge clk);
    while (!rdy_s && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    set_fields(wr, sz, uns, addr, wd);
    if (s) vb = 1'b1; else va = 1'b1;
    @(posedge clk);
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
    lat   = 1;
    hs_ok = 1'b1;
    while (!rv_s && lat < 40) begin
      if (rdy_s) hs_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (rdy_s) hs_ok = 1'b0;
    rd  = rd_s;
    flt = flt_s;
    @(negedge clk);
    if (rv_s || !rdy_s) hs_ok = 1'b0;
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".fault"}, 32'(flt), 32'(exp_flt));
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".hs"}, 32'(hs_ok), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst = 1'b1;
    va  = 1'b0;
    vb  = 1'b0;
    sel = 1'b0;
    set_fields(1'b0, SIZE_W, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(ra), 32'd1);
    chk("rst.valid", 32'(rva), 32'd0);
    chk("rst.rdata", da, 32'h0);
    chk("rst.fault", 32'(fa), 32'd0);

    // Word store/load, then sub-word extension.
    tx("sw40",   0, 1'b1, SIZE_W, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0,        1'b0, 3);
    tx("lw40",   0, 1'b0, SIZE_W, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0, 3);
    tx("lb43",   0, 1'b0, SIZE_B, 1'b0, 32'h43, 32'h0,        32'hFFFFFFDE, 1'b0, 3);
    tx("lbu43",  0, 1'b0, SIZE_B, 1'b1, 32'h43, 32'h0,        32'h000000DE, 1'b0, 3);
    tx("lh40",   0, 1'b0, SIZE_H, 1'b0, 32'h40, 32'h0,        32'hFFFFBEEF, 1'b0, 3);
    tx("lhu42",  0, 1'b0, SIZE_H, 1'b1, 32'h42, 32'h0,        32'h0000DEAD, 1'b0, 3);

    // Sub-word store merge.
    tx("sb41",   0, 1'b1, SIZE_B, 1'b0, 32'h41, 32'hFFFFFF12, 32'h0,        1'b0, 3);
    tx("lw40b",  0, 1'b0, SIZE_W, 1'b0, 32'h40, 32'h0,        32'hDEAD12EF, 1'b0, 3);
    tx("sh42",   0, 1'b1, SIZE_H, 1'b0, 32'h42, 32'h1234A5A5, 32'h0,        1'b0, 3);
    tx("lw40c",  0, 1'b0, SIZE_W, 1'b0, 32'h40, 32'h0,        32'hA5A512EF, 1'b0, 3);

    // Faults: misaligned, out of range (aliases word 0 in the array), size 11.
    tx("sw0",    0, 1'b1, SIZE_W, 1'b0, 32'h0,  32'h01234567, 32'h0,        1'b0, 3);
    tx("lwmis",  0, 1'b0, SIZE_W, 1'b0, 32'h42, 32'h0,        32'h0,        1'b1, 1);
    tx("lhmis",  0, 1'b0, SIZE_H, 1'b0, 32'h41, 32'h0,        32'h0,        1'b1, 1);
    tx("swoor",  0, 1'b1, SIZE_W, 1'b0, 32'(DEPTH*4), 32'hFFFFFFFF, 32'h0,  1'b1, 1);
    tx("lw0",    0, 1'b0, SIZE_W, 1'b0, 32'h0,  32'h0,        32'h01234567, 1'b0, 3);
    tx("sz11st", 0, 1'b1, 2'b11,  1'b0, 32'h40, 32'h0,        32'h0,        1'b1, 1);
    tx("sz11ld", 0, 1'b0, 2'b11,  1'b0, 32'h40, 32'h0,        32'h0,        1'b1, 1);
    tx("lw40d",  0, 1'b0, SIZE_W, 1'b0, 32'h40, 32'h0,        32'hA5A512EF, 1'b0, 3);

    // Reset during WAIT of a store drops it.
    tx("sw80",   0, 1'b1, SIZE_W, 1'b0, 32'h80, 32'h11111111, 32'h0,        1'b0, 3);
    sel = 1'b0;
    saw = 1'b0;
    @(negedge clk);
    set_fields(1'b1, SIZE_W, 1'b0, 32'h80, 32'hCAFEF00D);
    va = 1'b1;
    @(posedge clk);
    @(negedge clk);
    va = 1'b0;
    if (rva) saw = 1'b1;
    @(negedge clk);
    if (rva) saw = 1'b1;
    rst = 1'b1;
    #1;
    chk("mrst.ready_async", 32'(ra), 32'd1);
    @(negedge clk);
    if (rva) saw = 1'b1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rva) saw = 1'b1;
    end
    chk("mrst.nopulse", 32'(saw), 32'd0);
    chk("mrst.ready", 32'(ra), 32'd1);
    chk("mrst.rdata", da, 32'h0);
    tx("lw80",   0, 1'b0, SIZE_W, 1'b0, 32'h80, 32'h0,        32'h11111111, 1'b0, 3);

    // Zero-wait instance: single transactions, then back-to-back with valid held.
    tx("z.sw10", 1, 1'b1, SIZE_W, 1'b0, 32'h10, 32'h89ABCDEF, 32'h0,        1'b0, 1);
    tx("z.lb11", 1, 1'b0, SIZE_B, 1'b0, 32'h11, 32'h0,        32'hFFFFFFCD, 1'b0, 1);
    tx("z.lmis", 1, 1'b0, SIZE_H, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1);
    sel = 1'b1;
    @(negedge clk);
    chk("b2b.ready0", 32'(rb), 32'd1);
    set_fields(1'b1, SIZE_W, 1'b0, 32'h20, 32'h5A5A0FF0);
    vb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b.st_valid", 32'(rvb), 32'd1);
    chk("b2b.st_ready", 32'(rb), 32'd0);
    chk("b2b.st_rdata", db, 32'h0);
    set_fields(1'b0, SIZE_W, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("b2b.gap_valid", 32'(rvb), 32'd0);
    chk("b2b.gap_ready", 32'(rb), 32'd1);
    @(negedge clk);
    chk("b2b.ld_valid", 32'(rvb), 32'd1);
    chk("b2b.ld_rdata", db, 32'h5A5A0FF0);
    chk("b2b.ld_fault", 32'(fb), 32'd0);
    vb = 1'b0;
    @(negedge clk);
    chk("b2b.end_valid", 32'(rvb), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
